// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } rd_state_t;

  localparam int unsigned BUF_DEPTH_MIN = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Circular skid buffer: tail push, head pop, synchronous clear of pointers and occupancy.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < BUF_DEPTH_MIN) begin : g_depth_chk
    $error("stream_skid_buf: DEPTH below minimum");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping; clear wins over a same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= wrap_inc(tail);
      if (pop)  head <= wrap_inc(head);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[tail] <= wr_data;
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a registered-output synchronous FIFO into a valid/ready stream.
// Optional transfer counter enabled by FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = 3
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready,
  output logic                 busy
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] xfer_cnt
`endif
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = OCC_W + 1;

  rd_state_t        state;
  rd_state_t        state_nxt;
  logic             pend;
  logic [OCC_W-1:0] occ;
  logic             push;
  logic             pop;
  logic             credit_ok;

  // A read is only issued if its word is guaranteed a free buffer slot on landing.
  assign credit_ok = (SUM_W'(occ) + SUM_W'(pend)) < SUM_W'(BUF_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    if (flush) begin
      state_nxt = FLUSH;
    end else begin
      case (state)
        IDLE:    if (en) state_nxt = RUN;
        RUN: begin
          if (!en) state_nxt = IDLE;
          fifo_rd_en = !fifo_empty && credit_ok;
        end
        FLUSH:   if (!pend) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // pend marks the cycle in which a requested word is present on fifo_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= 1'b0;
    else        pend <= fifo_rd_en;
  end

  assign push    = pend && (state != FLUSH);
  assign m_valid = (occ != '0) && (state != FLUSH);
  assign pop     = m_valid && m_ready;
  assign busy    = (state != IDLE) || (occ != '0) || pend;

  stream_skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .clear     (flush),
    .wr_data   (fifo_dout),
    .head_data (m_data),
    .occ       (occ)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  // Counts accepted words; survives flush, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   xfer_cnt <= '0;
    else if (pop) xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
  end
`endif

`ifndef SYNTHESIS
  a_no_empty_read: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rd_en && fifo_empty));
  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occ <= OCC_W'(BUF_DEPTH));
  a_data_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m_valid && !m_ready && !flush) |=> $stable(m_data));
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural FIFO and stream reference model.
module tb_fifo_rd_stream;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned BUF_DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic             flush = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_dout = '0;
  logic             fifo_rd_en;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready = 1'b0;
  logic             busy;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0]      xfer_cnt;
`endif

  fifo_rd_stream #(.WIDTH(WIDTH), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy)
`ifdef FIFO_RD_STREAM_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] fq[$];      // FIFO contents
  logic [WIDTH-1:0] push_q[$];  // writes queued by stimulus, land on next edge
  logic [WIDTH-1:0] exp_q[$];   // words read from FIFO, not yet delivered
  int               rd_cyc_q[$];
  int               cyc = 0;
  int               n_rd = 0;
  int               n_deliv = 0;
  logic [WIDTH-1:0] last_word = '0;
  bit               underflow = 1'b0;

  task automatic chk(input string name, input bit ok, input longint act, input longint req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural FIFO: one-cycle registered read, not first-word-fall-through.
  always @(posedge clk) begin
    logic [WIDTH-1:0] w;
    cyc++;
    if (fifo_rd_en) begin
      if (fq.size() == 0) begin
        underflow = 1'b1;
      end else begin
        w = fq.pop_front();
        fifo_dout <= w;
        exp_q.push_back(w);
        rd_cyc_q.push_back(cyc);
        n_rd++;
      end
    end
    while (push_q.size() > 0) fq.push_back(push_q.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  // Monitor: compares each accepted word against the reference order.
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic             en_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_prev = 1'b0;
      en_prev   = 1'b0;
    end else begin
      if (hold_prev) chk("hold_data", m_data == prev_data, m_data, prev_data);
      chk("outstanding", exp_q.size() <= BUF_DEPTH, exp_q.size(), BUF_DEPTH);
      if (m_valid && m_ready) begin
        chk("sb_nonempty", exp_q.size() != 0, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          chk("sb_data", m_data == exp_q[0], m_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
        last_word = m_data;
        n_deliv++;
      end
      if (fifo_rd_en) begin
        chk("rd_while_empty", !fifo_empty, fifo_empty, 0);
        chk("rd_not_allowed", !(flush || (!en && !en_prev)), fifo_rd_en, 0);
      end
      if (flush) exp_q.delete();
      hold_prev = m_valid && !m_ready && !flush;
      prev_data = m_data;
      en_prev   = en;
    end
  end

  initial begin
    int base;
    int d0;
    int run;
    bit got;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_en", fifo_rd_en == 1'b0, fifo_rd_en, 0);
    chk("rst_m_valid", m_valid == 1'b0, m_valid, 0);
    chk("rst_m_data", m_data == '0, m_data, 0);
    chk("rst_busy", busy == 1'b0, busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Streaming 0x01..0x10 with consumer always ready
    for (int i = 1; i <= 16; i++) push_q.push_back(WIDTH'(i));
    tick(2);
    base = n_rd;
    d0   = n_deliv;
    en = 1'b1;
    m_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = m_valid;
    end
    chk("first_valid_seen", got, got, 1);
    if (got && rd_cyc_q.size() > base)
      chk("first_word_latency", (cyc - rd_cyc_q[base]) == 1, cyc - rd_cyc_q[base], 1);
    run = 1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (m_valid && run == k + 1) run++;
    end
    chk("stream_run", run == 16, run, 16);
    @(negedge clk);
    chk("stream_end", m_valid == 1'b0, m_valid, 0);
    tick(2);
    chk("stream_count", (n_deliv - d0) == 16, n_deliv - d0, 16);

    // Backpressure mid-stream
    d0 = n_deliv;
    for (int i = 0; i < 12; i++) push_q.push_back(WIDTH'(8'h20 + i));
    tick(4);
    m_ready = 1'b0;
    tick(10);
    @(negedge clk);
    chk("bp_outstanding", exp_q.size() == BUF_DEPTH, exp_q.size(), BUF_DEPTH);
    chk("bp_rd_stalled", fifo_rd_en == 1'b0, fifo_rd_en, 0);
    tick(1);
    m_ready = 1'b1;
    tick(20);
    chk("bp_drained", exp_q.size() == 0 && fq.size() == 0, exp_q.size() + fq.size(), 0);
    chk("bp_count", (n_deliv - d0) == 12, n_deliv - d0, 12);

    // Empty FIFO, then one late word
    d0 = n_deliv;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("empty_quiet", !fifo_rd_en && !m_valid, {fifo_rd_en, m_valid}, 0);
    end
    tick(1);
    push_q.push_back(8'hA5);
    tick(8);
    chk("late_word_once", (n_deliv - d0) == 1, n_deliv - d0, 1);
    chk("late_word_value", last_word == 8'hA5, last_word, 8'hA5);

    // Flush with two words buffered and one in flight
    m_ready = 1'b0;
    base = n_rd;
    d0   = n_deliv;
    for (int i = 0; i < 3; i++) push_q.push_back(WIDTH'(8'h51 + i));
    for (int k = 0; k < 20 && (n_rd - base) < 3; k++) tick(1);
    chk("flush_setup", exp_q.size() == 3, exp_q.size(), 3);
    flush = 1'b1;
    en = 1'b0;
    tick(1);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_valid_drop", m_valid == 1'b0, m_valid, 0);
    @(negedge clk);
    chk("flush_idle", busy == 1'b0, busy, 0);
    tick(1);
    m_ready = 1'b1;
    tick(6);
    chk("flush_dropped", (n_deliv - d0) == 0, n_deliv - d0, 0);
    chk("flush_still_idle", busy == 1'b0, busy, 0);

    // en dropped mid-stream: buffered words still delivered, no new reads
    m_ready = 1'b0;
    en = 1'b1;
    base = n_rd;
    d0   = n_deliv;
    for (int i = 0; i < 8; i++) push_q.push_back(WIDTH'(8'h70 + i));
    for (int k = 0; k < 20 && (n_rd - base) < 2; k++) tick(1);
    en = 1'b0;
    tick(3);
    m_ready = 1'b1;
    tick(10);
    chk("en_off_reads", (n_rd - base) >= 2 && (n_rd - base) <= 3, n_rd - base, 2);
    chk("en_off_delivered", (n_deliv - d0) == (n_rd - base), n_deliv - d0, n_rd - base);
    chk("en_off_fifo_left", fq.size() == 8 - (n_rd - base), fq.size(), 8 - (n_rd - base));
    en = 1'b1;
    tick(15);
    chk("en_on_drain", fq.size() == 0 && exp_q.size() == 0, fq.size() + exp_q.size(), 0);

    // Async reset mid-stream
    for (int i = 0; i < 16; i++) push_q.push_back(WIDTH'(8'h90 + i));
    tick(6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_en", fifo_rd_en == 1'b0, fifo_rd_en, 0);
    chk("arst_m_valid", m_valid == 1'b0, m_valid, 0);
    chk("arst_m_data", m_data == '0, m_data, 0);
    chk("arst_busy", busy == 1'b0, busy, 0);
    tick(1);
    rst_n = 1'b1;
    tick(25);
    chk("arst_drain", fq.size() == 0 && exp_q.size() == 0, fq.size() + exp_q.size(), 0);
    #2 rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("cnt_reset", xfer_cnt == 16'd0, xfer_cnt, 0);
`endif
    d0 = n_deliv;
    for (int i = 0; i < 16; i++) push_q.push_back(WIDTH'(8'hC0 + i));
    tick(25);
    chk("post_reset_count", (n_deliv - d0) == 16, n_deliv - d0, 16);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("cnt_16", xfer_cnt == 16'd16, xfer_cnt, 16);
`endif

    // Randomized traffic with flush pulses and random backpressure
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) push_q.push_back(WIDTH'($urandom));
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 9) < 6);
      flush   = !flush && ($urandom_range(0, 39) == 0);
      tick(1);
    end
    flush = 1'b0;
    en = 1'b0;
    m_ready = 1'b1;
    tick(10);
    chk("rand_drain", exp_q.size() == 0, exp_q.size(), 0);
    chk("rand_idle", busy == 1'b0, busy, 0);
    chk("no_underflow", underflow == 1'b0, underflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
